// File: rtl/adc_pkg.sv
// Shared types and frame geometry for the ADC SPI sampler.
package adc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StShift,
        StHold,
        StWr,
        StStart
    } state_t;

    localparam int unsigned ADC_BITS   = 12;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_START = 4;

    // Control bit driven in frame slot k; the channel address occupies slots 2..4, MSB first.
    function automatic logic frame_din(input logic [2:0] channel, input logic [4:0] k);
        logic bit_val;
        bit_val = 1'b0;
        case (k)
            5'd2:    bit_val = channel[2];
            5'd3:    bit_val = channel[1];
            5'd4:    bit_val = channel[0];
            default: bit_val = 1'b0;
        endcase
        return bit_val;
    endfunction

endpackage

// File: rtl/sclk_gen.sv
// SCLK half-period timer: flags the clock edges at which SCLK should rise or fall.
module sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic run_in,
    output logic rise_out,
    output logic fall_out
);

    localparam int unsigned CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic          high_q;
    logic          half_done;

    assign half_done = run_in && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_out  = half_done && !high_q;
    assign fall_out  = half_done && high_q;

    // Phase restarts high whenever the timer is idle, so every frame opens with a fall.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q  <= '0;
            high_q <= 1'b1;
        end else if (!run_in) begin
            cnt_q  <= '0;
            high_q <= 1'b1;
        end else if (half_done) begin
            cnt_q  <= '0;
            high_q <= !high_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic SPI ADC reader: one 16-bit frame per sample tick, then a write/start handshake
// to the downstream filter.
module adc_spi_sampler
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1250,
    parameter logic [2:0]  CHANNEL       = 3'd0
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                en_in,
    input  logic                busy_in,
    input  logic                adc_dout_in,
    output logic                adc_cs_n_out,
    output logic                adc_sclk_out,
    output logic                adc_din_out,
    output logic [ADC_BITS-1:0] x_out,
    output logic                wr_out,
    output logic                start_out,
    output logic                overrun_out
);

    localparam int unsigned PW = $clog2(SAMPLE_PERIOD);

    logic [PW-1:0]       per_cnt_q;
    logic                tick;
    state_t              state_q;
    logic [4:0]          bit_cnt_q;
    logic [ADC_BITS-1:0] sr_q;
    logic                run;
    logic                sclk_rise;
    logic                sclk_fall;

    assign tick = en_in && (per_cnt_q == PW'(SAMPLE_PERIOD - 1));
    assign run  = (state_q == StCsSetup) || (state_q == StShift) || (state_q == StHold);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            per_cnt_q <= '0;
        end else if (!en_in || tick) begin
            per_cnt_q <= '0;
        end else begin
            per_cnt_q <= per_cnt_q + 1'b1;
        end
    end

    sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .run_in  (run),
        .rise_out(sclk_rise),
        .fall_out(sclk_fall)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            adc_cs_n_out <= 1'b1;
            adc_sclk_out <= 1'b1;
            adc_din_out  <= 1'b0;
            x_out        <= '0;
            wr_out       <= 1'b0;
            start_out    <= 1'b0;
            overrun_out  <= 1'b0;
        end else begin
            wr_out    <= 1'b0;
            start_out <= 1'b0;
            if (tick && (state_q != StIdle)) begin
                overrun_out <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        state_q      <= StCsSetup;
                        adc_cs_n_out <= 1'b0;
                    end
                end
                StCsSetup: begin
                    if (sclk_fall) begin
                        state_q      <= StShift;
                        adc_sclk_out <= 1'b0;
                        adc_din_out  <= frame_din(CHANNEL, 5'd0);
                        bit_cnt_q    <= '0;
                    end
                end
                StShift: begin
                    // bit_cnt_q counts completed rises, so it also names the next slot to drive.
                    if (sclk_rise) begin
                        adc_sclk_out <= 1'b1;
                        bit_cnt_q    <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q >= 5'(DATA_START)) begin
                            sr_q <= {sr_q[ADC_BITS-2:0], adc_dout_in};
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt_q == 5'(FRAME_BITS)) begin
                            state_q <= StHold;
                        end else begin
                            adc_sclk_out <= 1'b0;
                            adc_din_out  <= frame_din(CHANNEL, bit_cnt_q);
                        end
                    end
                end
                StHold: begin
                    if (sclk_rise) begin
                        state_q      <= StWr;
                        adc_cs_n_out <= 1'b1;
                        if (busy_in) begin
                            overrun_out <= 1'b1;
                        end else begin
                            x_out  <= sr_q;
                            wr_out <= 1'b1;
                        end
                    end
                end
                StWr: begin
                    state_q   <= wr_out ? StStart : StIdle;
                    start_out <= wr_out;
                end
                StStart: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench: a nominal sampler (period 200, channel 5) and an over-driven one (period 100).
module tb_adc_spi_sampler;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        en[2];
    logic        busy[2];
    logic        dout[2] = '{1'b0, 1'b0};
    logic        cs_n[2];
    logic        sclk[2];
    logic        din[2];
    logic        wr[2];
    logic        start[2];
    logic        overrun[2];
    logic [11:0] x0;
    logic [11:0] x1;

    always #5 clk_in = ~clk_in;

    adc_spi_sampler #(
        .CLK_DIV      (4),
        .SAMPLE_PERIOD(200),
        .CHANNEL      (3'd5)
    ) u_dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_in       (en[0]),
        .busy_in     (busy[0]),
        .adc_dout_in (dout[0]),
        .adc_cs_n_out(cs_n[0]),
        .adc_sclk_out(sclk[0]),
        .adc_din_out (din[0]),
        .x_out       (x0),
        .wr_out      (wr[0]),
        .start_out   (start[0]),
        .overrun_out (overrun[0])
    );

    adc_spi_sampler #(
        .CLK_DIV      (4),
        .SAMPLE_PERIOD(100),
        .CHANNEL      (3'd0)
    ) u_dut_fast (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_in       (en[1]),
        .busy_in     (busy[1]),
        .adc_dout_in (dout[1]),
        .adc_cs_n_out(cs_n[1]),
        .adc_sclk_out(sclk[1]),
        .adc_din_out (din[1]),
        .x_out       (x1),
        .wr_out      (wr[1]),
        .start_out   (start[1]),
        .overrun_out (overrun[1])
    );

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          wr_cnt[2];
    int          wr_cyc_last[2];
    int          wr_cyc_prev[2];
    int          start_cnt[2];
    int          start_cyc_last[2];
    int          cs_fall_cnt[2];
    int          cs_fall_cyc[2];
    int          sclk_edges[2];
    int          fcnt[2];
    int          rcnt[2];
    int          din_bad;
    int          start_bad;
    int          both_hi;
    logic [15:0] din_frame;
    logic [15:0] frm;
    logic [11:0] adc_val[2];
    logic        cs_p[2]   = '{1'b1, 1'b1};
    logic        sclk_p[2] = '{1'b1, 1'b1};
    logic        din_p[2]  = '{1'b0, 1'b0};
    logic        wr_p[2]   = '{1'b0, 1'b0};
    logic        rst_p     = 1'b1;

    // ADC model and bus monitor; runs on the inactive edge so all DUT outputs are settled.
    always @(negedge clk_in) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (cs_p[i] && !cs_n[i]) begin
                cs_fall_cnt[i]++;
                cs_fall_cyc[i] = cyc;
                fcnt[i]        = 0;
                rcnt[i]        = 0;
                sclk_edges[i]  = 0;
            end
            if (!cs_n[i] && (sclk[i] != sclk_p[i])) sclk_edges[i]++;
            if (!cs_n[i] && sclk_p[i] && !sclk[i] && (fcnt[i] < 16)) begin
                frm     = {4'h0, adc_val[i]};
                dout[i] = frm[15 - fcnt[i]];
                fcnt[i]++;
            end
            if ((i == 0) && !cs_n[i] && !sclk_p[i] && sclk[i] && (rcnt[i] < 16)) begin
                din_frame[15 - rcnt[i]] = din[i];
                rcnt[i]++;
            end
            if (rst_in && rst_p && (din[i] != din_p[i]) && !(sclk_p[i] && !sclk[i])) din_bad++;
            if (wr[i]) begin
                wr_cnt[i]++;
                wr_cyc_prev[i] = wr_cyc_last[i];
                wr_cyc_last[i] = cyc;
            end
            if (start[i]) begin
                start_cnt[i]++;
                start_cyc_last[i] = cyc;
                if (!wr_p[i]) start_bad++;
            end
            if (wr[i] && start[i]) both_hi++;
            cs_p[i]   = cs_n[i];
            sclk_p[i] = sclk[i];
            din_p[i]  = din[i];
            wr_p[i]   = wr[i];
        end
        rst_p = rst_in;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
        #1;
    endtask

    task automatic wait_wr(input int i, input int target, input string tag);
        int n = 0;
        while ((wr_cnt[i] < target) && (n < 400)) begin
            step(1);
            n++;
        end
        check_eq(tag, 32'(wr_cnt[i] >= target), 32'd1);
    endtask

    task automatic wait_cs_fall(input int i, input string tag);
        int n    = 0;
        int snap = cs_fall_cnt[i];
        while ((cs_fall_cnt[i] == snap) && (n < 400)) begin
            step(1);
            n++;
        end
        check_eq(tag, cs_fall_cnt[i] - snap, 32'd1);
    endtask

    task automatic wait_cs_high(input int i, input string tag);
        int n = 0;
        while ((cs_n[i] !== 1'b1) && (n < 400)) begin
            step(1);
            n++;
        end
        check_eq(tag, 32'(cs_n[i]), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap_wr;
        int snap_start;
        int snap_cs;
        int n;
        en[0]      = 1'b0;
        en[1]      = 1'b0;
        busy[0]    = 1'b0;
        busy[1]    = 1'b0;
        adc_val[0] = 12'hA5C;
        adc_val[1] = 12'h3C7;
        #1 rst_in  = 1'b0;
        step(3);
        check_eq("rst_cs_n", 32'(cs_n[0]), 32'd1);
        check_eq("rst_sclk", 32'(sclk[0]), 32'd1);
        check_eq("rst_din", 32'(din[0]), 32'd0);
        check_eq("rst_x", x0, 32'd0);
        check_eq("rst_wr", 32'(wr[0]), 32'd0);
        check_eq("rst_start", 32'(start[0]), 32'd0);
        check_eq("rst_overrun", 32'(overrun[0]), 32'd0);
        rst_in = 1'b1;
        step(2);

        // Nominal conversion of 0xA5C.
        en[0] = 1'b1;
        wait_wr(0, 1, "a5c_wr_seen");
        check_eq("a5c_x", x0, 32'hA5C);
        check_eq("a5c_latency", wr_cyc_last[0] - cs_fall_cyc[0] + 1, 32'd137);
        step(2);
        check_eq("a5c_start_next", start_cyc_last[0] - wr_cyc_last[0], 32'd1);
        check_eq("din_frame", din_frame, 32'h2800);
        check_eq("a5c_no_overrun", 32'(overrun[0]), 32'd0);

        // Filter busy at write time: sample dropped.
        adc_val[0] = 12'h123;
        busy[0]    = 1'b1;
        snap_wr    = wr_cnt[0];
        snap_start = start_cnt[0];
        wait_cs_fall(0, "busy_frame_start");
        wait_cs_high(0, "busy_frame_end");
        step(3);
        check_eq("busy_x_kept", x0, 32'hA5C);
        check_eq("busy_no_wr", wr_cnt[0] - snap_wr, 32'd0);
        check_eq("busy_no_start", start_cnt[0] - snap_start, 32'd0);
        check_eq("busy_overrun", 32'(overrun[0]), 32'd1);
        busy[0] = 1'b0;

        // Reset at SCLK edge 8 aborts the frame.
        adc_val[0] = 12'h5A3;
        wait_cs_fall(0, "abort_frame_start");
        n = 0;
        while ((sclk_edges[0] < 8) && (n < 100)) begin
            step(1);
            n++;
        end
        check_eq("abort_edge8", 32'(sclk_edges[0]), 32'd8);
        rst_in = 1'b0;
        #1;
        check_eq("abort_cs_n", 32'(cs_n[0]), 32'd1);
        check_eq("abort_x", x0, 32'd0);
        check_eq("abort_sclk", 32'(sclk[0]), 32'd1);
        check_eq("abort_overrun", 32'(overrun[0]), 32'd0);
        snap_wr = wr_cnt[0];
        step(4);
        check_eq("abort_no_wr", wr_cnt[0] - snap_wr, 32'd0);
        rst_in = 1'b1;
        wait_wr(0, snap_wr + 1, "post_abort_wr_seen");
        check_eq("post_abort_x", x0, 32'h5A3);
        check_eq("post_abort_latency", wr_cyc_last[0] - cs_fall_cyc[0] + 1, 32'd137);
        check_eq("post_abort_one_wr", wr_cnt[0] - snap_wr, 32'd1);
        step(3);

        // Exactly 1000 enabled cycles at period 200.
        en[0]  = 1'b0;
        rst_in = 1'b0;
        step(2);
        rst_in = 1'b1;
        step(2);
        snap_wr = wr_cnt[0];
        en[0]   = 1'b1;
        repeat (1000) @(posedge clk_in);
        @(negedge clk_in);
        #1;
        en[0] = 1'b0;
        step(300);
        check_eq("period_wr_count", wr_cnt[0] - snap_wr, 32'd5);
        check_eq("period_spacing", wr_cyc_last[0] - wr_cyc_prev[0], 32'd200);
        snap_cs = cs_fall_cnt[0];
        step(500);
        check_eq("disabled_no_cs", cs_fall_cnt[0] - snap_cs, 32'd0);
        check_eq("disabled_cs_high", 32'(cs_n[0]), 32'd1);

        // Period shorter than a frame: tick in SHIFT is dropped, frame still intact.
        check_eq("fast_overrun_clear", 32'(overrun[1]), 32'd0);
        en[1] = 1'b1;
        wait_wr(1, 1, "fast_wr_seen");
        check_eq("fast_x", x1, 32'h3C7);
        check_eq("fast_latency", wr_cyc_last[1] - cs_fall_cyc[1] + 1, 32'd137);
        check_eq("fast_overrun", 32'(overrun[1]), 32'd1);
        step(3);
        check_eq("fast_start_next", start_cyc_last[1] - wr_cyc_last[1], 32'd1);
        en[1] = 1'b0;
        step(200);

        check_eq("din_only_on_fall", din_bad, 32'd0);
        check_eq("start_after_wr", start_bad, 32'd0);
        check_eq("wr_start_exclusive", both_hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_spi_sampler.md
ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk_in cycles per SCLK half-period (min 2).
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 1250, meaning clk_in cycles between conversion starts (min 34*CLK_DIV+4).
REQ-003 SHALL have parameter CHANNEL, default 3'd0, meaning ADC input channel address.
REQ-004 SHALL have port clk_in  input  1  system clock; the block has one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port en_in  input  1  sampling enable.
REQ-007 SHALL have port busy_in  input  1  downstream filter still processing the previous sample.
REQ-008 SHALL have port adc_dout_in  input  1  serial data from the ADC.
REQ-009 SHALL have port adc_cs_n_out  output  1  ADC chip select, active-low.
REQ-010 SHALL have port adc_sclk_out  output  1  ADC serial clock; idles high.
REQ-011 SHALL have port adc_din_out  output  1  serial address/control to the ADC.
REQ-012 SHALL have port x_out  output  12  last accepted sample, unsigned.
REQ-013 SHALL have port wr_out  output  1  one-cycle strobe; x_out is new this cycle; drives the filter sample write.
REQ-014 SHALL have port start_out  output  1  one-cycle strobe the cycle after wr_out; drives the filter start.
REQ-015 SHALL have port overrun_out  output  1  sticky flag; a sample or tick was dropped.

Function
REQ-016 SHALL run a period counter 0..SAMPLE_PERIOD-1 while en_in=1, issuing a tick in the cycle it equals SAMPLE_PERIOD-1, then wrap to 0; with en_in=0 it SHALL hold at 0.
REQ-017 SHALL implement states IDLE, CS_SETUP, SHIFT, HOLD, WR, START.
REQ-018 IDLE->CS_SETUP on tick; CS_SETUP SHALL drive adc_cs_n_out=0 with adc_sclk_out=1 for CLK_DIV cycles.
REQ-019 SHIFT SHALL produce 16 SCLK periods, each low CLK_DIV cycles then high CLK_DIV cycles (32*CLK_DIV cycles total).
REQ-020 adc_din_out SHALL change only on SCLK falling edges; frame bit k (k=0 first) = CHANNEL[4-k] for k=2..4, else 0.
REQ-021 adc_dout_in SHALL be sampled in the clk cycle SCLK goes 0->1; frame bits 4..15 form the sample, MSB first; bits 0..3 are discarded.
REQ-022 HOLD SHALL keep adc_cs_n_out=0, adc_sclk_out=1 for CLK_DIV cycles, then deassert adc_cs_n_out on entry to WR.
REQ-023 In WR, if busy_in=0: x_out SHALL load the sample and wr_out=1 for that cycle, then START asserts start_out=1 for one cycle, then IDLE.
REQ-024 In WR, if busy_in=1: x_out SHALL remain unchanged, no wr_out/start_out, overrun_out SHALL set, next state IDLE.
REQ-025 wr_out SHALL assert exactly 34*CLK_DIV+1 cycles after the tick cycle.
REQ-026 A tick occurring outside IDLE SHALL be dropped and SHALL set overrun_out.
REQ-027 en_in deasserted mid-conversion: current conversion SHALL complete normally; no further ticks.
REQ-028 overrun_out SHALL clear only on reset.
REQ-029 wr_out and start_out SHALL never be high in the same cycle.

Reset
REQ-030 On rst_in=0, asynchronously: state IDLE, counters 0, adc_cs_n_out=1, adc_sclk_out=1, adc_din_out=0, x_out=0, wr_out=0, start_out=0, overrun_out=0.
REQ-031 Reset mid-frame SHALL abort the frame with no wr_out; after release, the first tick occurs SAMPLE_PERIOD cycles after en_in is seen high.

Structure
REQ-032 Package adc_pkg SHALL hold the state enum, ADC_BITS=12, FRAME_BITS=16 and DATA_START=4.
REQ-033 SCLK timing SHALL be a sub-module sclk_gen (half-period counter; rise/fall pulses), instantiated once.

Verification
REQ-034 ADC model returns 0xA5C, CLK_DIV=4, busy_in=0 -> x_out=0xA5C with wr_out 137 cycles after tick, start_out next cycle.
REQ-035 CHANNEL=5 -> adc_din_out frame bits 2,3,4 = 1,0,1; all other bits 0; changes only on SCLK falls.
REQ-036 busy_in=1 during WR, model returns 0x123 after previous 0xA5C -> x_out stays 0xA5C, no strobes, overrun_out=1.
REQ-037 rst_in low at SCLK edge 8 -> adc_cs_n_out=1 and x_out=0 immediately, no wr_out; next frame after release is correct.
REQ-038 SAMPLE_PERIOD=200, en_in=1 for 1000 cycles -> exactly 5 wr_out pulses spaced 200 cycles apart; en_in=0 -> adc_cs_n_out stays 1.
REQ-039 SAMPLE_PERIOD forced below 34*CLK_DIV+4 in a bench-only build -> tick during SHIFT sets overrun_out and frame completes intact.
